// File: rtl/pixel_stream_ingress.sv
// pixel_stream_ingress
//   Ingress stage for the blur pipeline pixel input. Accepts a raster pixel
//   stream, decouples it through a small first-word-fall-through FIFO, tags
//   each pixel with end-of-line from a column/row position tracker, and
//   pulses frame_done after the end-of-frame pixel leaves the FIFO.
//
//   Optional feature macro: PIXEL_INGRESS_LAST_CHECK_EN
//     defined   -> err_last goes sticky-high when in_last disagrees with the
//                  tracked position (last must be on col IMG_W-1, row IMG_H-1)
//     undefined -> err_last tied to 0
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   in_data    upstream pixel
//   in_valid   upstream pixel valid
//   in_last    upstream end-of-frame marker
//   in_ready   ingress can accept (registered state only)
//   out_data   FIFO head pixel
//   out_valid  FIFO head valid
//   out_last   head carries in_last
//   out_eol    head is column IMG_W-1
//   out_ready  downstream accepts head
//   frame_done one-cycle pulse the cycle after an out_last word is popped
//   level      FIFO occupancy 0..DEPTH
//   err_last   sticky framing error
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A source holding valid=1 keeps its data stable until the transfer;
// ready never depends combinationally on the other side's valid or ready.
module pixel_stream_ingress #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int IMG_W  = 260,
  parameter int IMG_H  = 258
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic                     out_eol,
  input  logic                     out_ready,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int EW = DATA_W + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Entry layout: {last, eol, data}
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [EW-1:0] head;
  logic          run;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          eol_tag;
  logic          frame_done_q;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  assign full      = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign empty     = (wptr == rptr);
  assign in_ready  = run & ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = wptr - rptr;
  assign eol_tag   = (col == COL_LAST);

  assign head       = mem[rptr[AW-1:0]];
  assign out_data   = head[DATA_W-1:0];
  assign out_eol    = head[DATA_W];
  assign out_last   = head[DATA_W+1];
  assign frame_done = frame_done_q;

  // run holds in_ready low for the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr[AW-1:0]] <= {in_last, eol_tag, in_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (push) begin
      if (eol_tag) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= pop & out_last;
    end
  end

`ifdef PIXEL_INGRESS_LAST_CHECK_EN
  logic err_q;
  logic last_exp;

  assign last_exp = eol_tag && (row == ROW_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (push && (in_last != last_exp)) begin
      err_q <= 1'b1;
    end
  end

  assign err_last = err_q;
`else
  assign err_last = 1'b0;
`endif

endmodule
